// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory with a
// req/ready handshake, and loads the IF/ID pipeline register.  Redirects that
// arrive while a request is still outstanding send the FSM to DROP so the
// stale response is swallowed instead of entering the pipeline.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_flush,
  input  logic        jump,
  input  logic        bne,
  input  logic        jr,
  input  logic [25:0] jump_addr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic        w_in_fetch;
  logic        w_issued;
  logic        w_redirect;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_pc4;
  logic [31:0] w_target;

  // In FETCH the live request address is the PC itself; afterwards it is the
  // captured req_addr, so the address stays stable until memory answers.
  assign w_in_fetch = (r_state == S_FETCH);
  assign w_cur_addr = w_in_fetch ? r_pc : r_req_addr;
  assign w_cur_pc4  = w_cur_addr + 32'd4;
  assign w_issued   = w_in_fetch ? ~stall : 1'b1;
  assign w_redirect = jr | bne | jump;

  assign imem_req   = ~reset & w_issued;
  assign imem_addr  = w_cur_addr;

  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;

  // Redirect target selection: jr has highest priority, then bne, then jump.
  always_comb begin
    w_target = {w_cur_pc4[31:28], jump_addr, 2'b00};
    if (jr) begin
      w_target = jr_target;
    end else if (bne) begin
      w_target = branch_target;
    end
  end

  // Fetch FSM with PC, request address and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_ifid_instr <= NOP;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      if (w_in_fetch && !stall) begin
        r_req_addr <= r_pc;
      end

      if (w_redirect) begin
        // Redirect beats flush and stall; an unanswered request becomes stale.
        r_pc         <= w_target;
        r_ifid_instr <= NOP;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
        r_state      <= (w_issued && !imem_ready) ? S_DROP : S_FETCH;
      end else if (IF_flush) begin
        // Bubble this cycle; a completing response is thrown away and the
        // same PC is fetched again, an unanswered one keeps waiting.
        r_ifid_instr <= NOP;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
        if (w_issued && imem_ready) begin
          r_state <= S_FETCH;
        end else if (w_issued && w_in_fetch) begin
          r_state <= S_WAIT;
        end
      end else if (stall) begin
        // PC and IF/ID hold; only a stale response may still be retired.
        if (r_state == S_DROP && imem_ready) begin
          r_state <= S_FETCH;
        end
      end else begin
        unique case (r_state)
          S_FETCH, S_WAIT: begin
            if (imem_ready) begin
              r_ifid_instr <= imem_rdata;
              r_ifid_pc4   <= w_cur_pc4;
              r_ifid_valid <= 1'b1;
              r_pc         <= w_cur_pc4;
              r_state      <= S_FETCH;
            end else begin
              r_ifid_instr <= NOP;
              r_ifid_pc4   <= 32'd0;
              r_ifid_valid <= 1'b0;
              r_state      <= S_WAIT;
            end
          end
          S_DROP: begin
            if (imem_ready) begin
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule
